// File: rtl/cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and helpers for the set-associative cache controller.
//   state_t        controller state encoding
//   MAX_WAYS       widest way vector the helper function accepts
//   onehot_to_idx  index of the lowest set bit of a (up to 4-bit) way vector
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

   localparam int MAX_WAYS = 4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_HIT    = 4'd1,
      S_VICTIM = 4'd2,
      S_WB     = 4'd3,
      S_FILL   = 4'd4,
      S_CWR    = 4'd5,
      S_CRD    = 4'd6,
      S_FIN    = 4'd7,
      S_ERR    = 4'd8
   } state_t;

   // Lowest set bit wins, so the same function serves both "first invalid
   // way" and "decode the one-hot LRU way". An all-zero vector maps to 0.
   function automatic logic [1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = MAX_WAYS - 1; i >= 0; i--) begin
         if (vec[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cache_assoc_controller_if.sv
// -----------------------------------------------------------------------------
// cache_assoc_controller_if
// Bundles the processor, way-array and memory-bank signals of the cache
// controller.
//   modport master : the controller (drives comp/way_en/.../err)
//   modport slave  : the environment (processor, way arrays, memory banks)
// Inputs to the controller : global_rd, global_wr, hit, valid, dirty,
//                            lru_way, cache_err, mem_err, mem_stall
// Outputs of the controller: comp, way_en, cache_write, word_sel, mem_rd,
//                            mem_wr, lru_upd, global_hit, stall, done, err
// -----------------------------------------------------------------------------
interface cache_assoc_controller_if #(
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4
);
   localparam int OFF_W = $clog2(LINE_WORDS);

   logic              global_rd;
   logic              global_wr;
   logic [WAYS-1:0]   hit;
   logic [WAYS-1:0]   valid;
   logic [WAYS-1:0]   dirty;
   logic [WAYS-1:0]   lru_way;
   logic              cache_err;
   logic              mem_err;
   logic              mem_stall;

   logic              comp;
   logic [WAYS-1:0]   way_en;
   logic              cache_write;
   logic [OFF_W-1:0]  word_sel;
   logic              mem_rd;
   logic              mem_wr;
   logic              lru_upd;
   logic              global_hit;
   logic              stall;
   logic              done;
   logic              err;

   modport master (
      input  global_rd, global_wr, hit, valid, dirty, lru_way,
             cache_err, mem_err, mem_stall,
      output comp, way_en, cache_write, word_sel, mem_rd, mem_wr,
             lru_upd, global_hit, stall, done, err
   );

   modport slave (
      output global_rd, global_wr, hit, valid, dirty, lru_way,
             cache_err, mem_err, mem_stall,
      input  comp, way_en, cache_write, word_sel, mem_rd, mem_wr,
             lru_upd, global_hit, stall, done, err
   );

endinterface

// File: rtl/mem_beat_counter.sv
// -----------------------------------------------------------------------------
// mem_beat_counter
// Memory beat sequencing for write-back and fill.
//   clk, rst     clock, synchronous active-high reset
//   clr          abandon the current burst (counter and pipe cleared)
//   run          a memory beat is being requested this cycle
//   fill         the burst is a line fill (feeds the read-latency pipe)
//   mem_stall    memory did not accept the beat this cycle
//   beat         word offset of the beat currently requested
//   last_beat    the final beat of the line is accepted this cycle
//   all_issued   every fill beat has been accepted; stop requesting
//   fill_we      a read word returns this cycle; write it into the way
//   fill_idx     word offset of the returning word
// -----------------------------------------------------------------------------
module mem_beat_counter #(
   parameter int LINE_WORDS = 4,
   parameter int MEM_LAT    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          run,
   input  logic                          fill,
   input  logic                          mem_stall,
   output logic [$clog2(LINE_WORDS)-1:0] beat,
   output logic                          last_beat,
   output logic                          all_issued,
   output logic                          fill_we,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   logic               accept;
   logic [MEM_LAT-1:0] pipe_vld;
   logic [OFF_W-1:0]   pipe_idx [MEM_LAT];

   assign accept    = run & ~mem_stall & ~all_issued;
   assign last_beat = accept & (beat == LAST);
   assign fill_we   = pipe_vld[MEM_LAT-1];
   assign fill_idx  = pipe_idx[MEM_LAT-1];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         beat       <= '0;
         all_issued <= 1'b0;
      end else if (accept) begin
         beat <= beat + 1'b1;            // power-of-2 line: wraps to 0
         if (beat == LAST) all_issued <= fill;
      end
   end

   // The latency pipe keeps shifting while issue is stalled, so every
   // accepted read returns exactly once, MEM_LAT cycles after acceptance.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= accept & fill;
         for (int i = 1; i < MEM_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   // NOTE: the index payload is not reset; it is only consumed when its valid
   // bit is set, and only the valid bits need a defined reset value.
   always_ff @(posedge clk) begin
      pipe_idx[0] <= beat;
      for (int i = 1; i < MEM_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
   end

endmodule

// File: rtl/cache_assoc_controller.sv
// -----------------------------------------------------------------------------
// cache_assoc_controller
// Control FSM of an N-way set-associative, write-back, write-allocate cache.
// Sequences compare, victim choice, line write-back, line fill and the final
// access, and reports hit/done/err to the processor memory stage.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   cache_assoc_controller_if.master (processor, way-array, memory)
// -----------------------------------------------------------------------------
module cache_assoc_controller
   import cache_ctrl_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4,
   parameter int MEM_LAT    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   cache_assoc_controller_if.master bus
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   state_t            state, next_state;
   logic              op_wr;       // latched request type (1 = write)
   logic [WAYS-1:0]   sel_way;     // hit way, then replacement victim

   logic              req;
   logic [WAYS-1:0]   hv;
   logic              single_hit;
   logic              multi_hit;
   logic [1:0]        victim_idx;
   logic [WAYS-1:0]   victim;
   logic              victim_dirty;

   logic              run_state;
   logic              clr;
   logic [OFF_W-1:0]  beat;
   logic              last_beat;
   logic              all_issued;
   logic              fill_we;
   logic [OFF_W-1:0]  fill_idx;

   assign req        = bus.global_rd | bus.global_wr;
   assign hv         = bus.hit & bus.valid;
   // x & (x-1) clears the lowest set bit: non-zero means two or more ways hit.
   assign multi_hit  = (hv & (hv - 1'b1)) != '0;
   assign single_hit = (hv != '0) && !multi_hit;

   // Prefer the lowest invalid way so no live line is evicted needlessly.
   always_comb begin
      if (WAYS == 1)
         victim_idx = 2'd0;
      else if (~bus.valid != '0)
         victim_idx = onehot_to_idx(MAX_WAYS'(~bus.valid));
      else
         victim_idx = onehot_to_idx(MAX_WAYS'(bus.lru_way));
   end

   assign victim       = WAYS'(1) << victim_idx;
   assign victim_dirty = (victim & bus.valid & bus.dirty) != '0;

   // Any state change abandons the burst, so the counter always starts a new
   // write-back or fill from beat 0 with an empty latency pipe.
   assign run_state = (state == S_WB) || (state == S_FILL);
   assign clr       = (next_state != state) || !run_state;

   mem_beat_counter #(
      .LINE_WORDS (LINE_WORDS),
      .MEM_LAT    (MEM_LAT)
   ) u_beat (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .run        (run_state),
      .fill       (state == S_FILL),
      .mem_stall  (bus.mem_stall),
      .beat       (beat),
      .last_beat  (last_beat),
      .all_issued (all_issued),
      .fill_we    (fill_we),
      .fill_idx   (fill_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         op_wr   <= 1'b0;
         sel_way <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && req) begin
            op_wr   <= bus.global_wr;     // rd & wr together is a write
            sel_way <= hv;
         end
         if (state == S_VICTIM) sel_way <= victim;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      next_state      = state;
      bus.comp        = 1'b1;
      bus.way_en      = '0;
      bus.cache_write = 1'b0;
      bus.word_sel    = '0;
      bus.mem_rd      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.lru_upd     = 1'b0;
      bus.global_hit  = 1'b0;
      bus.stall       = 1'b0;
      bus.done        = 1'b0;
      bus.err         = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (req) begin
               if (multi_hit) begin
                  next_state = S_ERR;
               end else if (single_hit) begin
                  next_state      = S_HIT;
                  bus.cache_write = bus.global_wr;
               end else begin
                  next_state = S_VICTIM;
               end
            end
         end
         S_HIT: begin
            bus.way_en     = sel_way;
            bus.lru_upd    = 1'b1;
            bus.global_hit = 1'b1;
            bus.done       = 1'b1;
            bus.stall      = 1'b1;
            next_state     = S_IDLE;
         end
         S_VICTIM: begin
            bus.stall  = 1'b1;
            next_state = victim_dirty ? S_WB : S_FILL;
         end
         S_WB: begin
            bus.stall    = 1'b1;
            bus.comp     = 1'b0;
            bus.way_en   = sel_way;
            bus.mem_wr   = 1'b1;
            bus.word_sel = beat;
            if (last_beat) next_state = S_FILL;
         end
         S_FILL: begin
            bus.stall       = 1'b1;
            bus.comp        = 1'b0;
            bus.way_en      = sel_way;
            bus.mem_rd      = !all_issued;
            bus.cache_write = fill_we;
            // A returning word owns the shared offset; otherwise it addresses
            // the beat being issued.
            bus.word_sel    = fill_we ? fill_idx : beat;
            if (fill_we && fill_idx == LAST) next_state = op_wr ? S_CWR : S_CRD;
         end
         S_CWR: begin
            bus.stall       = 1'b1;
            bus.way_en      = sel_way;
            bus.cache_write = 1'b1;
            next_state      = S_FIN;
         end
         S_CRD: begin
            bus.stall  = 1'b1;
            bus.way_en = sel_way;
            next_state = S_FIN;
         end
         S_FIN: begin
            bus.stall   = 1'b1;
            bus.way_en  = sel_way;
            bus.done    = 1'b1;
            bus.lru_upd = 1'b1;
            next_state  = S_IDLE;
         end
         S_ERR: begin
            bus.stall  = 1'b1;
            bus.done   = 1'b1;
            bus.err    = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase

      // Errors pre-empt every normal transition outside IDLE.
      if (state != S_IDLE && (bus.cache_err || bus.mem_err)) next_state = S_ERR;
   end

endmodule

// File: tb/tb_cache_assoc_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_assoc_controller
// Self-checking bench. Each transaction is expanded by a trace builder into
// per-cycle input vectors and expected outputs, derived from the request
// type, the way status bits and a per-cycle memory-stall mask. One compare
// process checks every cycle; literal expectations on completion cycle and
// beat counts pin the trace builder itself.
// -----------------------------------------------------------------------------
module tb_cache_assoc_controller;

   localparam int WAYS = 2;
   localparam int LW   = 4;
   localparam int LAT  = 2;
   localparam int OW   = $clog2(LW);

   typedef struct packed {
      logic            rst;
      logic            rd;
      logic            wr;
      logic [WAYS-1:0] hit;
      logic [WAYS-1:0] valid;
      logic [WAYS-1:0] dirty;
      logic [WAYS-1:0] lru;
      logic            cerr;
      logic            merr;
      logic            mstall;
   } in_t;

   typedef struct packed {
      logic            comp;
      logic [WAYS-1:0] way_en;
      logic            cache_write;
      logic [OW-1:0]   word_sel;
      logic            mem_rd;
      logic            mem_wr;
      logic            lru_upd;
      logic            global_hit;
      logic            stall;
      logic            done;
      logic            err;
   } out_t;

   logic clk;
   logic rst;

   cache_assoc_controller_if #(.WAYS(WAYS), .LINE_WORDS(LW)) bus ();

   cache_assoc_controller #(
      .WAYS       (WAYS),
      .LINE_WORDS (LW),
      .MEM_LAT    (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;

   in_t  in_q [$];
   out_t ex_q [$];
   logic ws_q [$];

   logic     chk_en = 1'b0;
   out_t     cur_o;
   logic     cur_ws;
   int       cyc_idx;
   string    tname;
   int       done_idx;
   int       fill_cnt;
   int       wb_cnt;
   logic [LW-1:0] fill_mask;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic out_t idle_out();
      out_t o;
      o      = '0;
      o.comp = 1'b1;
      return o;
   endfunction

   function automatic out_t err_out();
      out_t o;
      o       = idle_out();
      o.done  = 1'b1;
      o.err   = 1'b1;
      o.stall = 1'b1;
      return o;
   endfunction

   function automatic logic stall_at(input logic [63:0] stl, input int c);
      return (c >= 0 && c < 64) ? stl[c] : 1'b0;
   endfunction

   task automatic push(input in_t b, input out_t o, input logic ws);
      in_q.push_back(b);
      ex_q.push_back(o);
      ws_q.push_back(ws);
   endtask

   task automatic truncate(input int keep);
      while (in_q.size() > keep) begin
         void'(in_q.pop_back());
         void'(ex_q.pop_back());
         void'(ws_q.pop_back());
      end
   endtask

   // Expand one processor request into its cycle-by-cycle trace. err_at /
   // rst_at (>= 0) inject an error or a reset on that cycle of the trace.
   task automatic build(input logic rd, input logic wr,
                        input logic [WAYS-1:0] h, input logic [WAYS-1:0] v,
                        input logic [WAYS-1:0] d, input logic [WAYS-1:0] l,
                        input logic [63:0] stl, input int err_at,
                        input logic err_is_mem, input int rst_at);
      in_t b, z, tmp;
      out_t o;
      logic ws, s;
      logic [WAYS-1:0] hv, vic;
      int c, nh, k, issued, written;
      int pend_c [$];
      int pend_i [$];

      in_q.delete(); ex_q.delete(); ws_q.delete();
      z = '0;
      b = '0; b.rd = rd; b.wr = wr; b.hit = h; b.valid = v; b.dirty = d; b.lru = l;
      hv = h & v;
      nh = $countones(hv);
      c  = 0;

      // request cycle
      o = idle_out();
      if ((rd || wr) && nh == 1) o.cache_write = wr;
      b.mstall = stall_at(stl, c); push(b, o, 1'b0); c++;

      if (rd || wr) begin
         if (nh > 1) begin
            b.mstall = stall_at(stl, c); push(b, err_out(), 1'b0); c++;
         end else if (nh == 1) begin
            o = idle_out(); o.way_en = hv; o.lru_upd = 1'b1; o.global_hit = 1'b1;
            o.done = 1'b1; o.stall = 1'b1;
            b.mstall = stall_at(stl, c); push(b, o, 1'b0); c++;
         end else begin
            vic = '0;
            for (int w = WAYS - 1; w >= 0; w--) if (!v[w]) vic = WAYS'(1) << w;
            if (vic == '0) vic = l;
            if (WAYS == 1) vic = WAYS'(1);
            o = idle_out(); o.stall = 1'b1;
            b.mstall = stall_at(stl, c); push(b, o, 1'b0); c++;
            if ((vic & v & d) != '0) begin
               k = 0;
               while (k < LW && c < 200) begin
                  s = stall_at(stl, c);
                  o = idle_out(); o.comp = 1'b0; o.way_en = vic; o.mem_wr = 1'b1;
                  o.word_sel = OW'(k); o.stall = 1'b1;
                  b.mstall = s; push(b, o, 1'b1); c++;
                  if (!s) k++;
               end
            end
            issued = 0; written = 0;
            while (written < LW && c < 200) begin
               s = stall_at(stl, c);
               o = idle_out(); o.comp = 1'b0; o.way_en = vic; o.stall = 1'b1;
               o.mem_rd = (issued < LW);
               ws = 1'b0;
               if (pend_c.size() > 0 && pend_c[0] == c) begin
                  o.cache_write = 1'b1;
                  o.word_sel = OW'(pend_i[0]);
                  ws = 1'b1;
                  void'(pend_c.pop_front()); void'(pend_i.pop_front());
                  written++;
               end else if (o.mem_rd) begin
                  o.word_sel = OW'(issued);
                  ws = 1'b1;
               end
               if (o.mem_rd && !s) begin
                  pend_c.push_back(c + LAT);
                  pend_i.push_back(issued);
                  issued++;
               end
               b.mstall = s; push(b, o, ws); c++;
            end
            o = idle_out(); o.way_en = vic; o.stall = 1'b1; o.cache_write = wr;
            b.mstall = stall_at(stl, c); push(b, o, 1'b0); c++;
            o = idle_out(); o.way_en = vic; o.stall = 1'b1; o.done = 1'b1; o.lru_upd = 1'b1;
            b.mstall = stall_at(stl, c); push(b, o, 1'b0); c++;
         end
      end

      if (err_at >= 0 && err_at < in_q.size()) begin
         truncate(err_at + 1);
         tmp = in_q[err_at]; tmp.merr = err_is_mem; tmp.cerr = !err_is_mem; in_q[err_at] = tmp;
         push(z, err_out(), 1'b0);
      end
      if (rst_at >= 0 && rst_at < in_q.size()) begin
         truncate(rst_at + 1);
         tmp = in_q[rst_at]; tmp.rst = 1'b1; in_q[rst_at] = tmp;
         push(z, idle_out(), 1'b0);
      end
      push(z, idle_out(), 1'b0);   // quiet cycle back in IDLE
   endtask

   task automatic drive(input in_t b);
      rst           = b.rst;
      bus.global_rd = b.rd;
      bus.global_wr = b.wr;
      bus.hit       = b.hit;
      bus.valid     = b.valid;
      bus.dirty     = b.dirty;
      bus.lru_way   = b.lru;
      bus.cache_err = b.cerr;
      bus.mem_err   = b.merr;
      bus.mem_stall = b.mstall;
   endtask

   task automatic run(input string name);
      tname     = name;
      done_idx  = -1;
      fill_cnt  = 0;
      wb_cnt    = 0;
      fill_mask = '0;
      for (int i = 0; i < in_q.size(); i++) begin
         @(posedge clk); #1;
         drive(in_q[i]);
         cur_o   = ex_q[i];
         cur_ws  = ws_q[i];
         cyc_idx = i;
         chk_en  = 1'b1;
      end
      @(negedge clk); #1;
      chk_en = 1'b0;
   endtask

   // Per-cycle comparison of every output against the trace.
   always @(negedge clk) begin
      out_t g, e;
      if (chk_en) begin
         g.comp = bus.comp; g.way_en = bus.way_en; g.cache_write = bus.cache_write;
         g.word_sel = bus.word_sel; g.mem_rd = bus.mem_rd; g.mem_wr = bus.mem_wr;
         g.lru_upd = bus.lru_upd; g.global_hit = bus.global_hit; g.stall = bus.stall;
         g.done = bus.done; g.err = bus.err;
         e = cur_o;
         if (!cur_ws) begin
            g.word_sel = '0;
            e.word_sel = '0;
         end
         check($sformatf("%s[%0d]", tname, cyc_idx), 32'(g), 32'(e));
         if (bus.done && done_idx < 0) done_idx = cyc_idx;
         if (bus.cache_write && !bus.comp) begin
            fill_cnt++;
            fill_mask[bus.word_sel] = 1'b1;
         end
         if (bus.mem_wr && !bus.mem_stall) wb_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t z;
      out_t g;
      z = '0;
      drive(z);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      g.comp = bus.comp; g.way_en = bus.way_en; g.cache_write = bus.cache_write;
      g.word_sel = bus.word_sel; g.mem_rd = bus.mem_rd; g.mem_wr = bus.mem_wr;
      g.lru_upd = bus.lru_upd; g.global_hit = bus.global_hit; g.stall = bus.stall;
      g.done = bus.done; g.err = bus.err;
      check("reset_out", 32'(g), 32'(out_t'({1'b1, 12'b0})));
      @(posedge clk); #1;
      rst = 1'b0;

      // no request: stays in IDLE even with a matching way
      build(1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b01, 64'h0, -1, 1'b0, -1);
      run("idle_norq");
      check("idle_norq_done", done_idx, -1);

      // 1. read hit way 0
      build(1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 2'b01, 64'h0, -1, 1'b0, -1);
      run("rd_hit");
      check("rd_hit_done", done_idx, 1);
      check("rd_hit_fill", fill_cnt, 0);

      // rd & wr together act as a write hit on way 1
      build(1'b1, 1'b1, 2'b10, 2'b11, 2'b00, 2'b01, 64'h0, -1, 1'b0, -1);
      run("rdwr_hit");
      check("rdwr_hit_done", done_idx, 1);

      // 2. dirty write miss, victim = LRU way 1
      build(1'b0, 1'b1, 2'b00, 2'b11, 2'b10, 2'b10, 64'h0, -1, 1'b0, -1);
      run("wr_miss_dirty");
      check("wr_miss_done", done_idx, 13);
      check("wr_miss_wb", wb_cnt, 4);
      check("wr_miss_fill", fill_cnt, 4);
      check("wr_miss_mask", 32'(fill_mask), 32'hf);

      // 3. read miss, way 1 invalid (dirty bit on an invalid way is ignored)
      build(1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 64'h0, -1, 1'b0, -1);
      run("rd_miss_inv");
      check("rd_miss_done", done_idx, 9);
      check("rd_miss_wb", wb_cnt, 0);
      check("rd_miss_fill", fill_cnt, 4);
      check("rd_miss_mask", 32'(fill_mask), 32'hf);

      // 4. three stall cycles on write-back beat 2
      build(1'b0, 1'b1, 2'b00, 2'b11, 2'b10, 2'b10, 64'h70, -1, 1'b0, -1);
      run("wb_stall");
      check("wb_stall_done", done_idx, 16);
      check("wb_stall_wb", wb_cnt, 4);

      // stall on fill issue: pipe drains, each word written once
      build(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 64'h18, -1, 1'b0, -1);
      run("fill_stall");
      check("fill_stall_done", done_idx, 11);
      check("fill_stall_cnt", fill_cnt, 4);
      check("fill_stall_mask", 32'(fill_mask), 32'hf);

      // 5. multi-hit write -> ERR, no cache write
      build(1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b01, 64'h0, -1, 1'b0, -1);
      run("multi_hit");
      check("multi_hit_done", done_idx, 1);
      check("multi_hit_wr", fill_cnt, 0);

      // mem_err pulse during FILL
      build(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 64'h0, 4, 1'b1, -1);
      run("mem_err_fill");
      check("mem_err_done", done_idx, 5);

      // cache_err during write-back
      build(1'b0, 1'b1, 2'b00, 2'b11, 2'b01, 2'b01, 64'h0, 3, 1'b0, -1);
      run("cache_err_wb");
      check("cache_err_done", done_idx, 4);

      // 6. reset mid-FILL, then a normal read miss
      build(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 64'h0, -1, 1'b0, 5);
      run("rst_fill");
      check("rst_fill_done", done_idx, -1);
      build(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b10, 64'h0, -1, 1'b0, -1);
      run("after_rst");
      check("after_rst_done", done_idx, 9);
      check("after_rst_fill", fill_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
